// File: rtl/game_pkg.sv
// Shared game-flow constants for the sequencer, collector and display blocks.
package game_pkg;

  localparam int unsigned LVL_W     = 3;
  localparam int unsigned SCORE_MAX = 255;
  localparam logic [4:0]  ALL_CAPTURED = 5'b11111;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    LVL_DONE  = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4,
    WIN       = 3'd5
  } game_state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [7:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return (sum > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : sum[7:0];
  endfunction

endpackage

// File: rtl/level_sequencer_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_PER_SEC-1 while enabled, tick on terminal count.
module sec_tick_gen #(
  parameter int unsigned CLK_PER_SEC = 40_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller: level select, collector clear, score and countdown time.
// Optional lives/respawn support is enabled by defining LEVEL_SEQ_LIVES_EN.
module level_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS  = 3,
  parameter int unsigned CLK_PER_SEC = 40_000_000,
  parameter int unsigned LVL_TIME    = 60,
  parameter int unsigned DONE_HOLD   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             capture_point,
  input  logic [4:0]       captured,
  input  logic             crash,
  output logic [LVL_W-1:0] lvl,
  output logic             collect_clr,
  output logic [7:0]       score,
  output logic [6:0]       time_left,
  output logic [2:0]       game_state,
  output logic [1:0]       lives
);

  localparam int unsigned      HOLD_W    = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);
  localparam logic [6:0]        T_INIT    = 7'(LVL_TIME);
  localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0]  FIRST_LVL = LVL_W'(1);

  game_state_t      state;
  logic [LVL_W-1:0] lvl_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic             sec_tick;
  logic             all_cap;
  logic             fail;
  logic [7:0]       bonus;
  logic             prescale_en;
  logic             prescale_clr;

  assign all_cap     = (captured == ALL_CAPTURED);
  assign fail        = crash || (sec_tick && (time_left == 7'd1));
  assign bonus       = {7'd0, capture_point} + {1'b0, time_left};
  assign prescale_en = (state == PLAY) || (state == LVL_DONE) || (state == RESPAWN);
  // Tick-driven exits land on the terminal count and wrap to 0 by themselves;
  // only the event-driven exits out of PLAY need an explicit clear.
  assign prescale_clr = (state == PLAY) && (all_cap || crash);
  assign game_state   = state;

  sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_sec_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (prescale_clr),
    .en   (prescale_en),
    .tick (sec_tick)
  );

`ifdef LEVEL_SEQ_LIVES_EN
  logic [1:0] lives_q;
  assign lives = lives_q;
`else
  assign lives = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lvl_idx     <= FIRST_LVL;
      lvl         <= '0;
      collect_clr <= 1'b1;
      score       <= '0;
      time_left   <= T_INIT;
      hold_cnt    <= '0;
`ifdef LEVEL_SEQ_LIVES_EN
      lives_q     <= 2'd3;
`endif
    end else begin
      case (state)
        IDLE, GAME_OVER, WIN: begin
          if (start) begin
            state       <= PLAY;
            lvl_idx     <= FIRST_LVL;
            lvl         <= FIRST_LVL;
            collect_clr <= 1'b0;
            score       <= '0;
            time_left   <= T_INIT;
`ifdef LEVEL_SEQ_LIVES_EN
            lives_q     <= 2'd3;
`endif
          end
        end
        PLAY: begin
          if (all_cap) begin
            score       <= sat_add(score, bonus);
            state       <= LVL_DONE;
            hold_cnt    <= '0;
            lvl         <= '0;
            collect_clr <= 1'b1;
          end else begin
            if (capture_point) score <= sat_add(score, 8'd1);
            if (sec_tick && (time_left != '0)) time_left <= time_left - 7'd1;
            if (fail) begin
              lvl         <= '0;
              collect_clr <= 1'b1;
              hold_cnt    <= '0;
`ifdef LEVEL_SEQ_LIVES_EN
              if (lives_q > 2'd1) begin
                lives_q   <= lives_q - 2'd1;
                time_left <= T_INIT;
                state     <= RESPAWN;
              end else begin
                lives_q   <= '0;
                state     <= GAME_OVER;
              end
`else
              state <= GAME_OVER;
`endif
            end
          end
        end
        LVL_DONE: begin
          if (sec_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (lvl_idx == LAST_LVL) begin
                state <= WIN;
              end else begin
                lvl_idx     <= lvl_idx + LVL_W'(1);
                lvl         <= lvl_idx + LVL_W'(1);
                collect_clr <= 1'b0;
                time_left   <= T_INIT;
                state       <= PLAY;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        RESPAWN: begin
          if (sec_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt    <= '0;
              lvl         <= lvl_idx;
              collect_clr <= 1'b0;
              state       <= PLAY;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
